// File: rtl/control_block_if.sv
// control_block_if: request/accept channel between the test controller and the transaction transmitter
// Ports (master = controller side):
//   trans_valid_o  request valid         trans_addr_o  request address
//   trans_type_o   0 write, 1 read       trans_ready_i transmitter accepts request this cycle
//   trans_busy_i   transmitter still holds or executes a transaction
interface control_block_if #(parameter int ADDR_W = 32);
  logic              trans_valid_o;
  logic [ADDR_W-1:0] trans_addr_o;
  logic              trans_type_o;
  logic              trans_ready_i;
  logic              trans_busy_i;
  modport master(output trans_valid_o, trans_addr_o, trans_type_o, input trans_ready_i, trans_busy_i);
  modport slave(input trans_valid_o, trans_addr_o, trans_type_o, output trans_ready_i, trans_busy_i);
endinterface

// File: rtl/control_block.sv
// control_block: memory test sequencer issuing write/read requests over an address window
// Ports:
//   clk_i, rst_i (async, active-high)     start_i      one-cycle test start strobe
//   test_mode_i  0 write, 1 read, 2 write+check, 3 reserved (start ignored)
//   addr_mode_i  0 sequential, 1 LFSR random    start_addr_i/end_addr_i inclusive window
//   addr_step_i  sequential increment           trans_count_i addresses to exercise
//   bus          request channel (master)       cmp_error_i  compare mismatch strobe
//   test_busy_o, test_done_o (one-cycle), test_error_o (sticky), addr_cnt_o completed addresses
module control_block #(parameter int ADDR_W = 32) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        test_mode_i,
  input  logic              addr_mode_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] end_addr_i,
  input  logic [15:0]       addr_step_i,
  input  logic [31:0]       trans_count_i,
  control_block_if.master   bus,
  input  logic              cmp_error_i,
  output logic              test_busy_o,
  output logic              test_done_o,
  output logic              test_error_o,
  output logic [31:0]       addr_cnt_o
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, FLUSH} state_t;
  state_t            state;
  logic [1:0]        mode;
  logic              rnd;
  logic [ADDR_W-1:0] lo, hi, addr, next_addr;
  logic [15:0]       step;
  logic [31:0]       count, lfsr, lfsr_nxt, cnt_nxt;
  logic [ADDR_W:0]   seq_sum;
  logic              hs, wac, fin;
  assign lfsr_nxt = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  // one extra bit so a step past the top of the address space still wraps to the window start
  assign seq_sum = {1'b0, addr} + (ADDR_W+1)'(step);
  // random addresses use the LFSR value after this completion's advance
  assign next_addr = rnd ? lo + (lfsr_nxt[ADDR_W-1:0] & (hi - lo))
                         : (seq_sum > {1'b0, hi}) ? lo : seq_sum[ADDR_W-1:0];
  assign hs = bus.trans_valid_o && bus.trans_ready_i;
  assign wac = mode == 2'd2;
  // an address is done on its read in write+check, on any accept otherwise
  assign fin = hs && (state == READ || !wac);
  assign cnt_nxt = addr_cnt_o + 32'd1;
  assign bus.trans_valid_o = state == WRITE || state == READ;
  assign bus.trans_type_o = state == READ;
  assign bus.trans_addr_o = addr;
  assign test_busy_o = state != IDLE;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      mode <= 2'd0;
      rnd <= 1'b0;
      lo <= '0;
      hi <= '0;
      step <= 16'd0;
      count <= 32'd0;
      addr <= '0;
      lfsr <= 32'h1;
      addr_cnt_o <= 32'd0;
      test_done_o <= 1'b0;
      test_error_o <= 1'b0;
    end else begin
      test_done_o <= 1'b0;
      case (state)
        IDLE: if (start_i && test_mode_i != 2'd3) begin
          mode <= test_mode_i;
          rnd <= addr_mode_i;
          lo <= start_addr_i;
          hi <= end_addr_i;
          step <= addr_step_i;
          count <= trans_count_i;
          addr <= start_addr_i;
          lfsr <= 32'h1;
          addr_cnt_o <= 32'd0;
          test_error_o <= 1'b0;
          state <= trans_count_i == 32'd0 ? FLUSH : test_mode_i == 2'd1 ? READ : WRITE;
        end
        WRITE, READ: begin
          if (hs && state == WRITE && wac) state <= READ;
          if (fin) begin
            addr_cnt_o <= cnt_nxt;
            addr <= next_addr;
            lfsr <= lfsr_nxt;
            state <= cnt_nxt == count ? FLUSH : wac ? WRITE : state;
          end
          if (cmp_error_i) begin
            test_error_o <= 1'b1;
            state <= FLUSH;
          end
        end
        default: begin
          if (cmp_error_i) test_error_o <= 1'b1;
          if (!bus.trans_busy_i) begin
            test_done_o <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_control_block.sv
// tb_control_block: vector table, randomized runs against a reference model, and corner-case sequences
module tb_control_block;
  localparam int ADDR_W = 32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, amode = 1'b0, cmp_err = 1'b0;
  logic [1:0] tmode = 2'd0;
  logic [31:0] saddr = 32'd0, eaddr = 32'd0, tcount = 32'd0;
  logic [15:0] step = 16'd0;
  logic busy_o, done_o, err_o;
  logic [31:0] cnt_o;
  int checks = 0, failures = 0;
  logic [32:0] exp_q[$], got_q[$];
  always #5 clk = ~clk;
  control_block_if #(.ADDR_W(ADDR_W)) bus();
  control_block #(.ADDR_W(ADDR_W)) dut(
    .clk_i(clk), .rst_i(rst), .start_i(start), .test_mode_i(tmode), .addr_mode_i(amode),
    .start_addr_i(saddr), .end_addr_i(eaddr), .addr_step_i(step), .trans_count_i(tcount),
    .bus(bus), .cmp_error_i(cmp_err), .test_busy_o(busy_o), .test_done_o(done_o),
    .test_error_o(err_o), .addr_cnt_o(cnt_o));

  typedef struct {
    logic [1:0] m; logic r; logic [31:0] s, e; logic [15:0] st; int n; int pct;
    int exp_cnt; int exp_txn;
  } vec_t;
  vec_t vecs[7];
  logic [31:0] req35[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected {type, addr} stream derived from the window/step/LFSR rules
  task automatic build_expected(input logic [1:0] m, input logic r, input logic [31:0] s, e,
                                input logic [15:0] st, input int n);
    longint unsigned a = s;
    logic [31:0] l = 32'h1;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      if (m != 2'd1) exp_q.push_back({1'b0, a[31:0]});
      if (m != 2'd0) exp_q.push_back({1'b1, a[31:0]});
      l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
      if (r) a = 64'(s) + 64'(l & (e - s));
      else begin
        a = a + st;
        if (a > e) a = s;
      end
    end
  endtask

  task automatic start_test(input logic [1:0] m, input logic r, input logic [31:0] s, e,
                            input logic [15:0] st, input int n);
    @(negedge clk);
    tmode = m; amode = r; saddr = s; eaddr = e; step = st; tcount = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (!done_o && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " done"}, done_o, 1);
  endtask

  task automatic run_test(input string name, input vec_t v);
    int dones = 0, cyc = 0;
    bit stall = 0;
    logic last_busy = 1'b0;
    logic [32:0] held = '0;
    build_expected(v.m, v.r, v.s, v.e, v.st, v.n);
    got_q.delete();
    start_test(v.m, v.r, v.s, v.e, v.st, v.n);
    check({name, " busy"}, busy_o, 1);
    while (dones == 0 && cyc < 2000) begin
      if (stall) check({name, " stall hold"}, {bus.trans_valid_o, bus.trans_type_o, bus.trans_addr_o}, {1'b1, held});
      bus.trans_ready_i = $urandom_range(99) < v.pct;
      bus.trans_busy_i = $urandom_range(1);
      last_busy = bus.trans_busy_i;
      stall = bus.trans_valid_o && !bus.trans_ready_i;
      held = {bus.trans_type_o, bus.trans_addr_o};
      if (bus.trans_valid_o && bus.trans_ready_i) got_q.push_back(held);
      @(negedge clk);
      cyc++;
      if (done_o) dones++;
    end
    check({name, " done seen"}, dones, 1);
    check({name, " idle at done"}, busy_o, 0);
    check({name, " busy low before done"}, last_busy, 0);
    check({name, " addr_cnt"}, cnt_o, v.exp_cnt);
    check({name, " error"}, err_o, 0);
    check({name, " txn count"}, got_q.size(), v.exp_txn);
    check({name, " model count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      check($sformatf("%s txn%0d", name, k), got_q[k], exp_q[k]);
    @(negedge clk);
    check({name, " done single"}, done_o, 0);
  endtask

  task automatic err_seq(input bit same_hs);
    int cyc = 0;
    bus.trans_ready_i = 1'b1;
    bus.trans_busy_i = 1'b1;
    start_test(2'd0, 1'b0, 32'h0, 32'hFF, 16'd1, 10);
    while (cnt_o != 32'd3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("err reach3", cnt_o, 3);
    bus.trans_ready_i = same_hs;
    cmp_err = 1'b1;
    @(negedge clk);
    cmp_err = 1'b0;
    check("err valid drop", bus.trans_valid_o, 0);
    check("err flag", err_o, 1);
    check("err cnt", cnt_o, same_hs ? 4 : 3);
    repeat (3) begin
      @(negedge clk);
      check("err done wait", done_o, 0);
      check("err busy", busy_o, 1);
    end
    bus.trans_busy_i = 1'b0;
    @(negedge clk);
    check("err done", done_o, 1);
    check("err cnt final", cnt_o, same_hs ? 4 : 3);
    check("err flag final", err_o, 1);
    @(negedge clk);
  endtask

  initial begin
    bus.trans_ready_i = 1'b0;
    bus.trans_busy_i = 1'b0;
    vecs[0] = '{2'd0, 1'b0, 32'h100, 32'h10F, 16'd4, 6, 100, 6, 6};
    vecs[1] = '{2'd2, 1'b0, 32'h20, 32'hFF, 16'd1, 2, 100, 2, 4};
    vecs[2] = '{2'd1, 1'b0, 32'h0, 32'h1000, 16'h100, 20, 60, 20, 20};
    vecs[3] = '{2'd2, 1'b1, 32'h4000, 32'h40FF, 16'd0, 8, 50, 8, 16};
    vecs[4] = '{2'd0, 1'b1, 32'h10, 32'h17, 16'd0, 10, 70, 10, 10};
    vecs[5] = '{2'd1, 1'b0, 32'h300, 32'h3FF, 16'd0, 3, 80, 3, 3};
    vecs[6] = '{2'd0, 1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 16'd8, 5, 90, 5, 5};
    req35 = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h100, 32'h104};
    #1;
    check("rst valid", bus.trans_valid_o, 0);
    check("rst type", bus.trans_type_o, 0);
    check("rst addr", bus.trans_addr_o, 0);
    check("rst busy", busy_o, 0);
    check("rst done", done_o, 0);
    check("rst error", err_o, 0);
    check("rst cnt", cnt_o, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      run_test($sformatf("vec%0d", i), vecs[i]);
      if (i == 0)
        for (int k = 0; k < 6 && k < got_q.size(); k++)
          check($sformatf("write list %0d", k), got_q[k], {1'b0, req35[k]});
    end
    cmp_err = 1'b1;
    @(negedge clk);
    cmp_err = 1'b0;
    check("idle cmp ignored", err_o, 0);
    start_test(2'd3, 1'b0, 32'h10, 32'h20, 16'd1, 4);
    check("mode3 ignored busy", busy_o, 0);
    check("mode3 ignored valid", bus.trans_valid_o, 0);
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v.m = 2'($urandom_range(2));
      v.r = 1'($urandom_range(1));
      v.s = $urandom & 32'hFFFF_F000;
      v.e = v.s + $urandom_range(1, 300);
      v.st = 16'($urandom_range(64));
      v.n = $urandom_range(1, 12);
      v.pct = $urandom_range(40, 100);
      v.exp_cnt = v.n;
      v.exp_txn = v.m == 2'd2 ? 2 * v.n : v.n;
      run_test($sformatf("rand%0d", i), v);
    end
    bus.trans_ready_i = 1'b0;
    bus.trans_busy_i = 1'b0;
    start_test(2'd2, 1'b0, 32'h70, 32'h7F, 16'd1, 2);
    repeat (5) begin
      check("stall w", {bus.trans_valid_o, bus.trans_type_o, bus.trans_addr_o, cnt_o}, {2'b10, 32'h70, 32'd0});
      @(negedge clk);
    end
    bus.trans_ready_i = 1'b1;
    @(negedge clk);
    bus.trans_ready_i = 1'b0;
    repeat (5) begin
      check("stall r", {bus.trans_valid_o, bus.trans_type_o, bus.trans_addr_o, cnt_o}, {2'b11, 32'h70, 32'd0});
      @(negedge clk);
    end
    bus.trans_ready_i = 1'b1;
    @(negedge clk);
    bus.trans_ready_i = 1'b0;
    check("stall one inc", cnt_o, 1);
    check("stall next addr", {bus.trans_type_o, bus.trans_addr_o}, {1'b0, 32'h71});
    bus.trans_ready_i = 1'b1;
    wait_done("stall");
    check("stall final cnt", cnt_o, 2);
    err_seq(1'b0);
    err_seq(1'b1);
    bus.trans_busy_i = 1'b1;
    start_test(2'd0, 1'b0, 32'h40, 32'h80, 16'd1, 0);
    for (int i = 0; i < 3; i++) begin
      check("cnt0 no valid", bus.trans_valid_o, 0);
      check("cnt0 busy", busy_o, 1);
      check("cnt0 no done", done_o, 0);
      start = i == 1;
      tmode = 2'd1;
      tcount = 5;
      @(negedge clk);
    end
    start = 1'b0;
    bus.trans_busy_i = 1'b0;
    @(negedge clk);
    check("cnt0 done", done_o, 1);
    check("cnt0 cnt", cnt_o, 0);
    @(negedge clk);
    check("cnt0 start ignored", {done_o, busy_o, bus.trans_valid_o}, 0);
    bus.trans_ready_i = 1'b0;
    bus.trans_busy_i = 1'b1;
    start_test(2'd0, 1'b0, 32'h500, 32'h5FF, 16'd4, 10);
    @(negedge clk);
    check("pre-rst valid", bus.trans_valid_o, 1);
    #2 rst = 1'b1;
    #1;
    check("async rst valid", bus.trans_valid_o, 0);
    check("async rst addr", bus.trans_addr_o, 0);
    check("async rst type", bus.trans_type_o, 0);
    check("async rst busy", busy_o, 0);
    check("async rst cnt", cnt_o, 0);
    check("async rst err/done", {err_o, done_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no done after abort", {done_o, busy_o}, 0);
    end
    run_test("post-rst", vecs[3]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
